// File: rtl/parking_pkg.sv
// Shared parking definitions: datapath widths and the exit gate FSM states,
// also used by the upstream cost stage.
package parking_pkg;

  localparam int FEE_W  = 32;
  localparam int ID_W   = 4;
  localparam int COIN_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    CHANGE,
    OPEN,
    ABORT
  } gate_state_e;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that stops at zero; expired_o flags a zero count.
module cycle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/exit_fee_gate.sv
// Exit barrier controller: collects coins against a latched fee, returns
// change or refunds on timeout, then holds the gate open for a fixed time.
module exit_fee_gate
  import parking_pkg::*;
#(
  parameter int OPEN_CYCLES = 8,
  parameter int PAY_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exit_req,
  input  logic [ID_W-1:0]   car_id,
  input  logic [FEE_W-1:0]  fee,
  input  logic              coin_valid,
  input  logic [COIN_W-1:0] coin_value,
  output logic              busy,
  output logic [FEE_W-1:0]  amount_due,
  output logic              change_valid,
  output logic [FEE_W-1:0]  change_amount,
  output logic              refund_valid,
  output logic [FEE_W-1:0]  refund_amount,
  output logic              gate_open,
  output logic              done,
  output logic [ID_W-1:0]   done_car_id
);

  localparam int TMAX = (OPEN_CYCLES > PAY_TIMEOUT) ? OPEN_CYCLES : PAY_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  // Timer is loaded with N-1 so that it expires in the Nth cycle of the state.
  localparam logic [TW-1:0] OPEN_LD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] PAY_LD  = TW'(PAY_TIMEOUT - 1);

  function automatic logic [FEE_W-1:0] sat_add(input logic [FEE_W-1:0]  a,
                                               input logic [COIN_W-1:0] b);
    logic [FEE_W:0] sum;
    sum = {1'b0, a} + {{(FEE_W + 1 - COIN_W){1'b0}}, b};
    return sum[FEE_W] ? {FEE_W{1'b1}} : sum[FEE_W-1:0];
  endfunction

  gate_state_e      state_q, state_d;
  logic [FEE_W-1:0] fee_q, fee_d;
  logic [FEE_W-1:0] paid_q, paid_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [FEE_W-1:0] paid_sum;
  logic             tmr_load, tmr_dec, tmr_expired;
  logic [TW-1:0]    tmr_val;

  cycle_timer #(.CNT_W(TW)) u_timer (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (tmr_load),
    .dec_i      (tmr_dec),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    fee_d    = fee_q;
    paid_d   = paid_q;
    id_d     = id_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = OPEN_LD;
    paid_sum = sat_add(paid_q, coin_value);
    unique case (state_q)
      IDLE: begin
        if (exit_req) begin
          fee_d    = fee;
          id_d     = car_id;
          paid_d   = '0;
          tmr_load = 1'b1;
          if (fee == '0) begin
            state_d = OPEN;
          end else begin
            state_d = COLLECT;
            tmr_val = PAY_LD;
          end
        end
      end
      COLLECT: begin
        if (coin_valid) begin
          paid_d   = paid_sum;
          tmr_load = 1'b1;
          if (paid_sum > fee_q) begin
            state_d = CHANGE;
          end else if (paid_sum == fee_q) begin
            state_d = OPEN;
          end else begin
            tmr_val = PAY_LD;
          end
        end else if (tmr_expired) begin
          state_d = ABORT;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      CHANGE: begin
        tmr_load = 1'b1;
        state_d  = OPEN;
      end
      OPEN: begin
        if (tmr_expired) begin
          state_d = IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ABORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fee_q   <= '0;
      paid_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      fee_q   <= fee_d;
      paid_q  <= paid_d;
      id_q    <= id_d;
    end
  end

  // Outputs decode registered state only, so each pulse is glitch-free per cycle.
  assign busy          = (state_q != IDLE);
  assign amount_due    = (state_q == COLLECT) ? (fee_q - paid_q) : '0;
  assign change_valid  = (state_q == CHANGE);
  assign change_amount = change_valid ? (paid_q - fee_q) : '0;
  assign refund_valid  = (state_q == ABORT);
  assign refund_amount = refund_valid ? paid_q : '0;
  assign gate_open     = (state_q == OPEN);
  assign done          = gate_open && tmr_expired;
  assign done_car_id   = done ? id_q : '0;

endmodule

// File: tb/tb_exit_fee_gate.sv
// Scoreboard bench for exit_fee_gate: pulses are matched against expected
// events queued when the exit/coin stimulus is driven.
module tb_exit_fee_gate;

  localparam int OPEN_N = 8;
  localparam int PAY_N  = 64;
  localparam logic [1:0] K_CHG  = 2'd1;
  localparam logic [1:0] K_REF  = 2'd2;
  localparam logic [1:0] K_DONE = 2'd3;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        exit_req;
  logic [3:0]  car_id;
  logic [31:0] fee;
  logic        coin_valid;
  logic [7:0]  coin_value;
  logic        busy;
  logic [31:0] amount_due;
  logic        change_valid;
  logic [31:0] change_amount;
  logic        refund_valid;
  logic [31:0] refund_amount;
  logic        gate_open;
  logic        done;
  logic [3:0]  done_car_id;

  int   checks = 0;
  int   errors = 0;
  int   gate_hi = 0;
  int   gate_mark;
  exp_t sb[$];
  exp_t e_m;
  logic [1:0]  kind_m;
  logic [31:0] val_m;

  exit_fee_gate #(.OPEN_CYCLES(OPEN_N), .PAY_TIMEOUT(PAY_N)) dut (
    .clk           (clk),
    .reset         (reset),
    .exit_req      (exit_req),
    .car_id        (car_id),
    .fee           (fee),
    .coin_valid    (coin_valid),
    .coin_value    (coin_value),
    .busy          (busy),
    .amount_due    (amount_due),
    .change_valid  (change_valid),
    .change_amount (change_amount),
    .refund_valid  (refund_valid),
    .refund_amount (refund_amount),
    .gate_open     (gate_open),
    .done          (done),
    .done_car_id   (done_car_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  // Pulse monitor: every change/refund/done pulse must match the queue head.
  always @(negedge clk) begin
    if (gate_open) gate_hi++;
    if (change_valid || refund_valid || done) begin
      kind_m = change_valid ? K_CHG : (refund_valid ? K_REF : K_DONE);
      val_m  = change_valid ? change_amount :
               (refund_valid ? refund_amount : 32'(done_car_id));
      if (sb.size() == 0) begin
        chk("sb_unexpected_pulse", 32'(kind_m), 32'd0);
      end else begin
        e_m = sb.pop_front();
        chk("sb_kind", 32'(kind_m), 32'(e_m.kind));
        chk("sb_val", val_m, e_m.val);
      end
    end
    if (!change_valid) chk("change_amount_idle", change_amount, 32'd0);
    if (!refund_valid) chk("refund_amount_idle", refund_amount, 32'd0);
    if (!done)         chk("done_car_id_idle", 32'(done_car_id), 32'd0);
  end

  task automatic request(input logic [3:0] id, input logic [31:0] f);
    exit_req = 1'b1;
    car_id   = id;
    fee      = f;
    @(negedge clk);
    exit_req = 1'b0;
  endtask

  task automatic coin(input logic [7:0] v);
    coin_valid = 1'b1;
    coin_value = v;
    @(negedge clk);
    coin_valid = 1'b0;
  endtask

  // Called while observing the first OPEN cycle.
  task automatic expect_open();
    for (int i = 0; i < OPEN_N; i++) begin
      chk("gate_open", 32'(gate_open), 32'd1);
      chk("done_timing", 32'(done), 32'(i == OPEN_N - 1));
      @(negedge clk);
    end
    chk("gate_closed", 32'(gate_open), 32'd0);
    chk("busy_after_open", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; exit_req = 1'b0; car_id = '0; fee = '0;
    coin_valid = 1'b0; coin_value = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gate", 32'(gate_open), 32'd0);
    chk("rst_amount_due", amount_due, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    // Free exit accepted in the first cycle after reset.
    push(K_DONE, 32'd3);
    request(4'd3, 32'd0);
    expect_open();

    // Exact payment 10+10+5.
    push(K_DONE, 32'd5);
    request(4'd5, 32'd25);
    chk("due_25", amount_due, 32'd25);
    coin(8'd10);
    chk("due_15", amount_due, 32'd15);
    coin(8'd10);
    chk("due_5", amount_due, 32'd5);
    coin(8'd5);
    chk("due_0_open", amount_due, 32'd0);
    expect_open();

    // Overpayment 20+20 -> change 15.
    push(K_CHG, 32'd15);
    push(K_DONE, 32'd7);
    request(4'd7, 32'd25);
    coin(8'd20);
    chk("due_after_20", amount_due, 32'd5);
    coin(8'd20);
    chk("change_valid", 32'(change_valid), 32'd1);
    chk("change_gate", 32'(gate_open), 32'd0);
    @(negedge clk);
    expect_open();

    // Timeout after one coin -> refund 10, gate stays shut.
    gate_mark = gate_hi;
    push(K_REF, 32'd10);
    request(4'd8, 32'd30);
    coin(8'd10);
    for (int i = 0; i < PAY_N; i++) begin
      chk("timeout_busy", 32'(busy), 32'd1);
      chk("timeout_due", amount_due, 32'd20);
      chk("timeout_no_refund", 32'(refund_valid), 32'd0);
      @(negedge clk);
    end
    chk("refund_valid", 32'(refund_valid), 32'd1);
    @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_gate_never", 32'(gate_hi - gate_mark), 32'd0);

    // Second exit_req and stray coin during OPEN are ignored.
    push(K_DONE, 32'd9);
    request(4'd9, 32'd0);
    for (int i = 0; i < OPEN_N; i++) begin
      chk("open2_gate", 32'(gate_open), 32'd1);
      chk("open2_done", 32'(done), 32'(i == OPEN_N - 1));
      exit_req   = (i == 2);
      coin_valid = (i == 2);
      car_id     = 4'd2;
      fee        = 32'd40;
      coin_value = 8'd50;
      @(negedge clk);
    end
    exit_req = 1'b0; coin_valid = 1'b0;
    chk("open2_ignored_busy", 32'(busy), 32'd0);

    // Coin in the accept cycle is ignored; next request proceeds normally.
    push(K_DONE, 32'd4);
    coin_valid = 1'b1; coin_value = 8'd5;
    request(4'd4, 32'd5);
    coin_valid = 1'b0;
    chk("accept_coin_ignored", amount_due, 32'd5);
    coin(8'd5);
    expect_open();

    // Reset mid-payment with paid=15 discards without a refund.
    request(4'd1, 32'd40);
    coin(8'd10);
    coin(8'd5);
    chk("due_before_reset", amount_due, 32'd25);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_due", amount_due, 32'd0);
    chk("rst_mid_refund", 32'(refund_valid), 32'd0);
    push(K_DONE, 32'd12);
    request(4'd12, 32'd0);
    expect_open();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exit_fee_gate.md
EXIT_FEE_GATE -- requirements
Module: exit_fee_gate

Interface
REQ-001 The block SHALL have parameter OPEN_CYCLES, default 8, the number of cycles gate_open is held high.
REQ-002 The block SHALL have parameter PAY_TIMEOUT, default 64, the number of idle cycles without a coin before a payment aborts.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port exit_req, input, 1, a one-cycle pulse marking a car exit with a valid fee.
REQ-006 The block SHALL have port car_id, input, 4, the exiting car ID, sampled with exit_req.
REQ-007 The block SHALL have port fee, input, 32, the parking cost from the upstream cost stage, sampled with exit_req.
REQ-008 The block SHALL have ports coin_valid, input, 1, and coin_value, input, 8, a payment increment valid for one cycle.
REQ-009 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 The block SHALL have port amount_due, output, 32, equal to the remaining fee in COLLECT and 0 otherwise.
REQ-011 The block SHALL have ports change_valid, output, 1, and change_amount, output, 32, a one-cycle change-return pulse.
REQ-012 The block SHALL have ports refund_valid, output, 1, and refund_amount, output, 32, a one-cycle abort refund pulse.
REQ-013 The block SHALL have port gate_open, output, 1, the barrier drive.
REQ-014 The block SHALL have ports done, output, 1, and done_car_id, output, 4, a one-cycle pulse marking a completed exit.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, COLLECT, CHANGE, OPEN and ABORT.
REQ-016 In IDLE, exit_req=1 SHALL latch fee and car_id and clear paid; the next state SHALL be OPEN if fee==0, else COLLECT.
REQ-017 exit_req SHALL be ignored in every state other than IDLE; there is no queueing.
REQ-018 coin_valid SHALL be ignored outside COLLECT, including in the cycle in which exit_req is accepted.
REQ-019 In COLLECT, each coin_valid SHALL add coin_value to the 32-bit paid register, which saturates at 2^32-1.
REQ-020 Payment completion SHALL be evaluated on the updated paid value: if paid>fee the FSM goes to CHANGE, if paid==fee it goes to OPEN, otherwise it stays in COLLECT.
REQ-021 amount_due SHALL equal the latched fee minus paid and update the cycle after each coin is accepted.
REQ-022 CHANGE SHALL last one cycle, with change_valid=1 and change_amount=paid-fee, and then go to OPEN.
REQ-023 The timeout counter SHALL restart at entry to COLLECT and on every accepted coin.
REQ-024 After PAY_TIMEOUT consecutive coin-free cycles in COLLECT, the FSM SHALL go to ABORT.
REQ-025 ABORT SHALL last one cycle, with refund_valid=1 and refund_amount=paid (which may be 0), and then go to IDLE; the gate SHALL NOT open.
REQ-026 OPEN SHALL hold gate_open=1 for exactly OPEN_CYCLES cycles.
REQ-027 done=1 and done_car_id=latched car_id SHALL be asserted in the last OPEN cycle, after which the FSM goes to IDLE.
REQ-028 Latency SHALL be as follows: with fee==0, gate_open rises on the cycle after exit_req; with an exact payment, gate_open rises on the cycle after the final coin.
REQ-029 All pulse outputs SHALL be registered and SHALL be 0 outside their defined cycle; change_amount and refund_amount SHALL read 0 when their valid flag is low.

Reset
REQ-030 While reset=1 at a clock edge, the FSM SHALL go to IDLE and all registers and outputs SHALL clear to 0, including busy, gate_open, amount_due, paid and the counters.
REQ-031 A reset in any state, including mid-payment or with the gate open, SHALL discard the transaction without change or refund pulses.
REQ-032 The first exit_req SHALL be accepted in the first cycle after reset deasserts.

Structure
REQ-033 A shared parking package SHALL hold the FSM state enum and the constants FEE_W=32, ID_W=4 and COIN_W=8, and SHALL be reused by the upstream cost stage.
REQ-034 One sub-module, cycle_timer (a loadable down-counter with an expiry flag), SHALL be instantiated once and reused for both the pay timeout and the open duration.

Verification
REQ-035 The bench SHALL cover fee=0 with exit_req at cycle N: gate_open high for cycles N+1 to N+8, and done with the latched car_id at N+8.
REQ-036 The bench SHALL cover fee=25 paid with coins 10, 10, 5: amount_due steps 25 -> 15 -> 5 -> 0, no change pulse, and the gate opens the cycle after the last coin.
REQ-037 The bench SHALL cover fee=25 paid with coins 20, 20: change_valid with change_amount=15 for one cycle, followed by 8 OPEN cycles.
REQ-038 The bench SHALL cover fee=30 with one coin of 10 and then silence: after 64 idle cycles, refund_valid with refund_amount=10, return to IDLE, and gate_open never high.
REQ-039 The bench SHALL cover a second exit_req and stray coins arriving during OPEN: both are ignored, and a later exit_req in IDLE is accepted normally.
REQ-040 The bench SHALL cover reset asserted mid-COLLECT with paid=15: next cycle busy=0, amount_due=0 and no refund pulse.
